// File: rtl/nor_logic_unit_seq.sv
// Multi-cycle bitwise logic unit (NOR/AND/OR/XOR).
// Processes SLICE bits per clock, LSB slice first, under a start/busy/done
// handshake, and raises a zero flag for the completed result.
// WIDTH must be an integer multiple of SLICE.
module nor_logic_unit_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic             zero
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_NOR = 2'b00,
    OP_AND = 2'b01,
    OP_OR  = 2'b10,
    OP_XOR = 2'b11
  } op_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  op_e              op_q,    op_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic [WIDTH-1:0] res_q,   res_d;
  logic             zero_q,  zero_d;

  logic [SLICE-1:0] a_sl, b_sl, slice_res;
  logic             last_slice;

  assign last_slice = (cnt_q == CW'(N - 1));

  // Select the operand slice addressed by the counter and apply the latched op.
  always_comb begin
    // NOTE: every variable written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    a_sl = '0;
    b_sl = '0;
    for (int i = 0; i < N; i++) begin
      if (cnt_q == CW'(i)) begin
        a_sl = a_q[i*SLICE +: SLICE];
        b_sl = b_q[i*SLICE +: SLICE];
      end
    end
    unique case (op_q)
      OP_NOR:  slice_res = ~(a_sl | b_sl);
      OP_AND:  slice_res = a_sl & b_sl;
      OP_OR:   slice_res = a_sl | b_sl;
      default: slice_res = a_sl ^ b_sl;
    endcase
  end

  // Next-state logic: accept, per-slice result write, completion and zero flag.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    zero_d  = zero_q;
    unique case (state_q)
      RUN: begin
        for (int i = 0; i < N; i++) begin
          if (cnt_q == CW'(i)) res_d[i*SLICE +: SLICE] = slice_res;
        end
        if (last_slice) begin
          state_d = DONE;
          // res_d already carries the slice written on this edge, so the flag
          // reflects the complete result.
          zero_d  = (res_d == '0);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        // IDLE and DONE behave alike: a start here is accepted, so back-to-back
        // operations issue one per N+1 cycles. res is left untouched.
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          op_d    = op_e'(op);
          a_d     = a;
          b_d     = b;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the latched operands are ordinary registers, not a memory array,
    // so they are reset along with the rest; an abort leaves no stale state.
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= OP_NOR;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // that existed before this edge, independent of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
    end
  end

  // Outputs are decoded straight from registers; no input reaches them combinationally.
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign res  = res_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_nor_logic_unit_seq.sv
// Directed self-checking bench for nor_logic_unit_seq.
// Four instances share the clock, reset and operand buses: the 32/8 default
// build plus 32/32, 16/4 and 64/8 for the parameter sweep.
module tb_nor_logic_unit_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  start_w;
  logic [1:0]  op_tb;
  logic [63:0] a_tb, b_tb;

  logic [31:0] res0, res1;
  logic [15:0] res2;
  logic [63:0] res3;
  logic [3:0]  busy_w, done_w, zero_w;
  logic [63:0] res_w [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nor_logic_unit_seq #(.WIDTH(32), .SLICE(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_w[0]), .op(op_tb),
    .a(a_tb[31:0]), .b(b_tb[31:0]),
    .busy(busy_w[0]), .done(done_w[0]), .res(res0), .zero(zero_w[0]));

  nor_logic_unit_seq #(.WIDTH(32), .SLICE(32)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_w[1]), .op(op_tb),
    .a(a_tb[31:0]), .b(b_tb[31:0]),
    .busy(busy_w[1]), .done(done_w[1]), .res(res1), .zero(zero_w[1]));

  nor_logic_unit_seq #(.WIDTH(16), .SLICE(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_w[2]), .op(op_tb),
    .a(a_tb[15:0]), .b(b_tb[15:0]),
    .busy(busy_w[2]), .done(done_w[2]), .res(res2), .zero(zero_w[2]));

  nor_logic_unit_seq #(.WIDTH(64), .SLICE(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start_w[3]), .op(op_tb),
    .a(a_tb), .b(b_tb),
    .busy(busy_w[3]), .done(done_w[3]), .res(res3), .zero(zero_w[3]));

  assign res_w[0] = {32'b0, res0};
  assign res_w[1] = {32'b0, res1};
  assign res_w[2] = {48'b0, res2};
  assign res_w[3] = res3;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Bitwise reference model, masked to the instance width.
  function automatic logic [63:0] ref_op(input logic [1:0] o, input logic [63:0] x,
                                         input logic [63:0] y, input int w);
    logic [63:0] r, m;
    case (o)
      2'b00:   r = ~(x | y);
      2'b01:   r = x & y;
      2'b10:   r = x | y;
      default: r = x ^ y;
    endcase
    m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    return r & m;
  endfunction

  // Called at a negedge: present a request, leave start high across one posedge.
  task automatic issue(input int inst, input logic [1:0] o, input logic [63:0] x,
                       input logic [63:0] y);
    op_tb = o;
    a_tb  = x;
    b_tb  = y;
    start_w[inst] = 1'b1;
    @(negedge clk);
    start_w[inst] = 1'b0;
  endtask

  // Waits (bounded) for done, checking remaining latency and busy duration.
  task automatic wait_done(input int inst, input int exp_cyc, input string tag);
    int cyc   = 0;
    int nbusy = 0;
    while (done_w[inst] !== 1'b1 && cyc < 200) begin
      if (busy_w[inst] === 1'b1) nbusy++;
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(exp_cyc));
    check({tag, "_busy_cycles"}, 64'(nbusy), 64'(exp_cyc));
    check({tag, "_busy_at_done"}, 64'(busy_w[inst]), 64'd0);
  endtask

  int widths [4] = '{32, 32, 16, 64};
  int slices [4] = '{8, 32, 4, 8};

  initial begin
    int pulses;
    logic [63:0] x, y, e;
    start_w = '0;
    op_tb   = '0;
    a_tb    = '0;
    b_tb    = '0;
    rst_n   = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_res",  res_w[0], 64'd0);
    check("rst_busy", 64'(busy_w[0]), 64'd0);
    check("rst_done", 64'(done_w[0]), 64'd0);
    check("rst_zero", 64'(zero_w[0]), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // NOR, single operation
    issue(0, 2'b00, 64'h39, 64'h03);
    wait_done(0, 4, "nor1");
    check("nor1_res",  res_w[0], 64'hFFFF_FFC4);
    check("nor1_zero", 64'(zero_w[0]), 64'd0);

    // Back-to-back NOR issued in the DONE cycle, then AND back-to-back again
    issue(0, 2'b00, 64'h2, 64'h1);
    wait_done(0, 4, "nor2");
    check("nor2_res",  res_w[0], 64'hFFFF_FFFC);
    check("nor2_zero", 64'(zero_w[0]), 64'd0);
    issue(0, 2'b01, 64'h2, 64'h1);
    wait_done(0, 4, "and1");
    check("and1_res",  res_w[0], 64'h0);
    check("and1_zero", 64'(zero_w[0]), 64'd1);
    @(negedge clk);
    check("and1_done_pulse", 64'(done_w[0]), 64'd0);
    check("and1_res_hold",   res_w[0], 64'h0);
    check("and1_zero_hold",  64'(zero_w[0]), 64'd1);

    // XOR with a start (and changed operand) during busy that must be ignored
    issue(0, 2'b11, 64'hFFFF_0000, 64'h0F0F_0F0F);
    @(negedge clk);
    a_tb = 64'h0;
    op_tb = 2'b00;
    start_w[0] = 1'b1;
    @(negedge clk);
    start_w[0] = 1'b0;
    wait_done(0, 2, "xor1");
    check("xor1_res",  res_w[0], 64'hF0F0_0F0F);
    check("xor1_zero", 64'(zero_w[0]), 64'd0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done_w[0] === 1'b1) pulses++;
    end
    check("xor1_extra_done", 64'(pulses), 64'd0);

    // OR aborted by reset after two RUN edges
    issue(0, 2'b10, 64'h1234_0000, 64'h0000_5678);
    @(negedge clk);
    @(negedge clk);
    check("abort_busy_before", 64'(busy_w[0]), 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_res",  res_w[0], 64'd0);
    check("abort_busy", 64'(busy_w[0]), 64'd0);
    check("abort_done", 64'(done_w[0]), 64'd0);
    check("abort_zero", 64'(zero_w[0]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done_w[0] === 1'b1) pulses++;
    end
    check("abort_no_done", 64'(pulses), 64'd0);
    issue(0, 2'b10, 64'h1234_0000, 64'h0000_5678);
    wait_done(0, 4, "or1");
    check("or1_res",  res_w[0], 64'h1234_5678);
    check("or1_zero", 64'(zero_w[0]), 64'd0);
    @(negedge clk);

    // Parameter sweep: random operands for every op, plus a zero-result vector
    for (int inst = 1; inst < 4; inst++) begin
      for (int o = 0; o < 5; o++) begin
        x = {$urandom, $urandom};
        y = {$urandom, $urandom};
        if (o == 4) y = x;
        e = ref_op((o == 4) ? 2'b11 : 2'(o), x, y, widths[inst]);
        issue(inst, (o == 4) ? 2'b11 : 2'(o), x, y);
        wait_done(inst, widths[inst] / slices[inst], $sformatf("sweep%0d_op%0d", inst, o));
        check($sformatf("sweep%0d_op%0d_res", inst, o), res_w[inst], e);
        check($sformatf("sweep%0d_op%0d_zero", inst, o), 64'(zero_w[inst]),
              64'(e == 64'd0));
        @(negedge clk);
        check($sformatf("sweep%0d_op%0d_done_pulse", inst, o), 64'(done_w[inst]), 64'd0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nor_logic_unit_seq.md
# nor_logic_unit_seq

Parametrised, multi-cycle bitwise logic unit: the successor to the fixed 32-bit combinational NOR block. It computes NOR, AND, OR or XOR of two WIDTH-bit operands, processing SLICE bits per clock, LSB slice first, under a start/busy/done handshake. A zero flag is produced on completion. It sits beside the ALU datapath in place of the single-function NOR gate.

## Interface
- WIDTH, 32: operand and result width in bits.
- SLICE, 8: bits processed per cycle. WIDTH must be an integer multiple of SLICE. N = WIDTH/SLICE slices.
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- start  in  1  request; accepted only on an edge where busy=0.
- op  in  2  operation: 00 NOR, 01 AND, 10 OR, 11 XOR; latched at accept.
- a  in  WIDTH  operand A; latched at accept.
- b  in  WIDTH  operand B; latched at accept.
- busy  out  1  high while slices are being computed.
- done  out  1  one-cycle pulse: res and zero are final.
- res  out  WIDTH  result register.
- zero  out  1  high when the completed res is all zeros.

## Operation
- States: IDLE, RUN, DONE.
- Reset (async, rst_n=0): state IDLE, res=0, busy=0, done=0, zero=0, slice counter=0, latched operands/op=0.
- IDLE or DONE, start=1: latch a, b, op; clear counter; go to RUN; busy=1. res is not cleared at accept.
- IDLE or DONE, start=0: go to / stay in IDLE; done=0.
- RUN, each edge: res[cnt*SLICE +: SLICE] <= op(a_l, b_l) for that slice; cnt increments.
- RUN, on the edge writing slice N-1: go to DONE; busy=0; done=1; zero <= (final res == 0), evaluated on the complete result including the slice written on that edge.
- DONE lasts exactly one cycle. Back-to-back: start=1 in DONE is accepted like IDLE.
- start while busy=1: ignored. No queueing, no effect on latched operands or op.
- Changes to a, b, op after accept: no effect on the current operation.
- res during RUN holds a mix of new and previous slices: not valid until done.
- res and zero hold their values after done until slices of the next operation overwrite them. zero changes only on the edge that asserts done, or on reset.
- rst_n=0 mid-operation: immediate abort to reset values. No done is produced for the aborted operation.
- SLICE=WIDTH: N=1; the whole result is written on the single RUN edge.
- Counter width: ceil(log2(N)), minimum 1 bit. It wraps only by clearing at accept.

## Timing
- Edge k samples start=1 with busy=0. Edges k+1 … k+N write slices 0 … N-1.
- After edge k+N: done=1, busy=0, and res and zero are valid.
- After edge k+N+1: done=0, unless another operation has completed.
- Latency from accept to done = N cycles. Throughput: one operation per N+1 cycles with back-to-back start.
- busy is high for exactly N cycles per operation.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset, then WIDTH=32, SLICE=8, op=00 (NOR), a=0x00000039, b=0x00000003, start pulse -> busy high 4 cycles, done after 4 cycles, res=0xFFFFFFC4, zero=0.
- op=00 (NOR), a=0x00000002, b=0x00000001, issued back-to-back in the DONE cycle -> res=0xFFFFFFFC after 4 cycles. Then op=01 (AND) with the same operands -> res=0x00000000, zero=1.
- op=11 (XOR), a=0xFFFF0000, b=0x0F0F0F0F. Change a to 0 and assert start again two cycles after accept -> second start ignored, res=0xF0F00F0F, exactly one done pulse.
- op=10 (OR), a=0x12340000, b=0x00005678. Drop rst_n after 2 RUN cycles -> res=0, busy=0, done=0, zero=0 immediately. No done follows. A new start after release works normally.
- Parameter sweep with random operands, all four ops, checked against a bitwise reference model including latency N and the zero flag: (WIDTH=32, SLICE=32) gives latency 1; (WIDTH=16, SLICE=4) gives latency 4; (WIDTH=64, SLICE=8) gives latency 8.
